logic_fn_pipe: RTL and testbench

//  Parametrised, pipelined, multi-bit gate-network evaluator. Computes per bit
//  E = ~C and D = f(A,B,C), where f is selected by a run-time mode.

---
 rtl/logic_fn_pipe.sv | 102 ++++++++++
 tb/tb_logic_fn_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_fn_pipe.sv
// rtl/logic_fn_pipe.sv - pipelined bitwise gate-network evaluator with valid/ready handshake
// Optional LOGIC_FN_PARITY_EN adds out_par = ^D ^ ^E carried alongside each result.
module logic_fn_pipe #(
  parameter int WIDTH = 8,
  parameter int LAT   = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] E,
`ifdef LOGIC_FN_PARITY_EN
  output logic             out_par,
`endif
  output logic [CNT_W-1:0] count
);

  logic             w_stall;
  logic             w_adv;
  logic [WIDTH-1:0] w_fn;
  logic [WIDTH-1:0] w_nc;

  logic [LAT-1:0]   r_vld;
  logic [WIDTH-1:0] r_d [LAT];
  logic [WIDTH-1:0] r_e [LAT];
  logic [CNT_W-1:0] r_count;

  assign w_stall  = r_vld[LAT-1] & ~out_ready;
  assign w_adv    = ~w_stall;
  assign in_ready = w_adv;
  assign w_nc     = ~C;

  always_comb begin
    w_fn = A;
    case (mode)
      2'b00:   w_fn = (A & B) | w_nc;
      2'b01:   w_fn = (A | B) & w_nc;
      2'b10:   w_fn = A ^ B ^ C;
      default: w_fn = A;
    endcase
  end

  // Stage 0 holds the freshly evaluated result; later stages only delay it.
  // A cycle with in_valid low still advances, inserting a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_d[i] <= '0;
        r_e[i] <= '0;
      end
    end else if (w_adv) begin
      r_vld[0] <= in_valid;
      r_d[0]   <= w_fn;
      r_e[0]   <= w_nc;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_d[i]   <= r_d[i-1];
        r_e[i]   <= r_e[i-1];
      end
    end
  end

`ifdef LOGIC_FN_PARITY_EN
  logic [LAT-1:0] r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= '0;
    end else if (w_adv) begin
      r_par[0] <= (^w_fn) ^ (^w_nc);
      for (int i = 1; i < LAT; i++) begin
        r_par[i] <= r_par[i-1];
      end
    end
  end

  assign out_par = r_par[LAT-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (r_vld[LAT-1] && out_ready) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign out_valid = r_vld[LAT-1];
  assign D         = r_d[LAT-1];
  assign E         = r_e[LAT-1];
  assign count     = r_count;

endmodule

// File: tb/tb_logic_fn_pipe.sv
// tb/tb_logic_fn_pipe.sv - directed bench for logic_fn_pipe with scoreboard queue
module tb_logic_fn_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] mode;
  logic [7:0] a_i, b_i, c_i;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] d_o, e_o;
  logic [3:0] count;
  logic       par_o;

  logic       v1_in_valid, v1_in_ready, v1_out_valid;
  logic [1:0] v1_mode;
  logic [7:0] v1_a, v1_b, v1_c, v1_d, v1_e;
  logic [3:0] v1_count;
  logic       v1_par;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;

  logic_fn_pipe #(.WIDTH(8), .LAT(3), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .A(a_i), .B(b_i), .C(c_i),
    .out_valid(out_valid), .out_ready(out_ready), .D(d_o), .E(e_o),
`ifdef LOGIC_FN_PARITY_EN
    .out_par(par_o),
`endif
    .count(count)
  );

  logic_fn_pipe #(.WIDTH(8), .LAT(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
    .mode(v1_mode), .A(v1_a), .B(v1_b), .C(v1_c),
    .out_valid(v1_out_valid), .out_ready(1'b1), .D(v1_d), .E(v1_e),
`ifdef LOGIC_FN_PARITY_EN
    .out_par(v1_par),
`endif
    .count(v1_count)
  );

`ifndef LOGIC_FN_PARITY_EN
  assign par_o  = 1'b0;
  assign v1_par = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] fn(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    case (m)
      2'b00:   return (a & b) | ~c;
      2'b01:   return (a | b) & ~c;
      2'b10:   return a ^ b ^ c;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on output transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("sb_d", {24'd0, d_o}, {24'd0, x.d});
          chk("sb_e", {24'd0, e_o}, {24'd0, x.e});
`ifdef LOGIC_FN_PARITY_EN
          chk("sb_par", {31'd0, par_o}, {31'd0, (^x.d) ^ (^x.e)});
`endif
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{d: fn(mode, a_i, b_i, c_i), e: ~c_i});
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; mode = m; a_i = a; b_i = b; c_i = c;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
  endtask

  task automatic wait_out_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] hd, he, pa, pb, pc;
    logic [1:0] pm;
    int bi, stall_left, n0;
    logic [7:0] ba [6];
    logic [7:0] bb [6];
    logic [7:0] bc [6];
    logic [1:0] bm [6];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'b00; a_i = '0; b_i = '0; c_i = '0;
    v1_in_valid = 1'b0; v1_mode = 2'b00; v1_a = '0; v1_b = '0; v1_c = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_d", {24'd0, d_o}, 32'd0);
    chk("rst_e", {24'd0, e_o}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_par", {31'd0, par_o}, 32'd0);
    @(posedge clk);
    #1;

    // Test 1: single beat, three-edge latency, one-cycle valid
    send(2'b00, 8'hF0, 8'h3C, 8'hAA);
    @(negedge clk); chk("t1_lat_e1", {31'd0, out_valid}, 32'd0);
    @(negedge clk); chk("t1_lat_e2", {31'd0, out_valid}, 32'd0);
    @(negedge clk); chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_d", {24'd0, d_o}, 32'h75);
    chk("t1_e", {24'd0, e_o}, 32'h55);
`ifdef LOGIC_FN_PARITY_EN
    chk("t1_par", {31'd0, par_o}, 32'd1);
`endif
    @(negedge clk); chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Test 2: back-to-back beats
    send(2'b01, 8'h0F, 8'h30, 8'hAA);
    send(2'b10, 8'hFF, 8'h0F, 8'h33);
    wait_out_valid("t2_timeout");
    chk("t2_d0", {24'd0, d_o}, 32'h15);
    chk("t2_e0", {24'd0, e_o}, 32'h55);
    @(negedge clk);
    chk("t2_valid1", {31'd0, out_valid}, 32'd1);
    chk("t2_d1", {24'd0, d_o}, 32'hC3);
    chk("t2_e1", {24'd0, e_o}, 32'hCC);
    drain();

    // Test 3: 6-beat stream with a 5-cycle output stall after the first result
    for (int i = 0; i < 6; i++) begin
      bm[i] = 2'($urandom_range(0, 3));
      ba[i] = 8'($urandom); bb[i] = 8'($urandom); bc[i] = 8'($urandom);
    end
    n0 = n_out; bi = 0; stall_left = -1; hd = '0; he = '0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      in_valid = (bi < 6);
      if (bi < 6) begin
        mode = bm[bi]; a_i = ba[bi]; b_i = bb[bi]; c_i = bc[bi];
      end
      out_ready = !(stall_left > 0);
      @(negedge clk);
      if (!out_ready) begin
        chk("t3_in_ready_stall", {31'd0, in_ready}, 32'd0);
        chk("t3_valid_stall", {31'd0, out_valid}, 32'd1);
        if (stall_left == 5) begin
          hd = d_o; he = e_o;
        end else begin
          chk("t3_d_hold", {24'd0, d_o}, {24'd0, hd});
          chk("t3_e_hold", {24'd0, e_o}, {24'd0, he});
        end
        stall_left--;
      end else if (stall_left == -1 && out_valid) begin
        stall_left = 5;
      end
      if (in_valid && in_ready) bi++;
      @(posedge clk);
      #1;
      if (bi == 6 && sb.size() == 0) break;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("t3_beats_sent", bi, 32'd6);
    chk("t3_results", n_out - n0, 32'd6);
    chk("t3_sb_empty", sb.size(), 32'd0);

    // Test 4: 17 transfers from reset wrap the counter once
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 17; i++) send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom));
    drain();
    @(posedge clk); #1;
    chk("t4_count_wrap", {28'd0, count}, 32'd1);

    // Test 5: asynchronous reset with results in flight
    send(2'b00, 8'h11, 8'h22, 8'h33);
    send(2'b01, 8'h44, 8'h55, 8'h66);
    send(2'b10, 8'h77, 8'h88, 8'h99);
    wait_out_valid("t5_timeout");
    chk("t5_count_pre", {28'd0, count}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid_async", {31'd0, out_valid}, 32'd0);
    chk("t5_count_async", {28'd0, count}, 32'd0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_stale", {31'd0, out_valid}, 32'd0);
    end
    chk("t5_count_post", {28'd0, count}, 32'd0);

    // Test 6: LAT=1 instance, full throughput
    pm = '0; pa = '0; pb = '0; pc = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      v1_in_valid = 1'b1;
      v1_mode = 2'($urandom_range(0, 3));
      v1_a = 8'($urandom); v1_b = 8'($urandom); v1_c = 8'($urandom);
      @(negedge clk);
      if (i > 0) begin
        chk("t6_valid", {31'd0, v1_out_valid}, 32'd1);
        chk("t6_d", {24'd0, v1_d}, {24'd0, fn(pm, pa, pb, pc)});
        chk("t6_e", {24'd0, v1_e}, {24'd0, ~pc});
`ifdef LOGIC_FN_PARITY_EN
        chk("t6_par", {31'd0, v1_par}, {31'd0, (^fn(pm, pa, pb, pc)) ^ (^(~pc))});
`endif
      end
      pm = v1_mode; pa = v1_a; pb = v1_b; pc = v1_c;
    end
    v1_in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
